// File: rtl/dfilter_ctrl.sv
// dfilter_ctrl
//   Control and scheduling block for a bank of NCH digital noise filters.
//   - Prescaler that produces the shared one-clock sampling strobe refclk.
//   - Small register file for per-channel polarity and rise/fall filter times.
//   - Sticky capture of active/inactive edge pulses with a level interrupt.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   we, re            one-clock register write / read strobes
//   addr, wdata       register address and write data
//   rdata, rvalid     registered read data (held) and one-clock valid pulse
//   refclk            filter sampling strobe, shared by all channels
//   pol               per-channel polarity (1 = high active)
//   flt_rise_st/fall  per-channel filter times, channel n at [n*BW +: BW]
//   flt_level         per-channel filtered level (readable at LEVEL)
//   act_edge/inact_edge  per-channel edge pulses captured into STATUS
//   irq               registered level interrupt
//
// Register map
//   0x0 CTRL   [0] en, [31:16] presc
//   0x1 POL    [NCH-1:0]
//   0x2 IRQ_EN [7:0] act enables, [15:8] inact enables
//   0x3 STATUS [7:0] act sticky, [15:8] inact sticky (write 1 to clear)
//   0x4 LEVEL  flt_level (read only)
//   0x8+n FLTn [BW-1:0] rise, [BW+15:16] fall
module dfilter_ctrl #(
  parameter int          NCH       = 4,
  parameter int          BW        = 8,
  parameter logic [15:0] PRESC_INI = 16'd0,
  parameter logic [7:0]  FLT_INI   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              refclk,
  output logic [NCH-1:0]    pol,
  output logic [NCH*BW-1:0] flt_rise_st,
  output logic [NCH*BW-1:0] flt_fall_st,
  input  logic [NCH-1:0]    flt_level,
  input  logic [NCH-1:0]    act_edge,
  input  logic [NCH-1:0]    inact_edge,
  output logic              irq
);

  localparam logic [BW-1:0] FLT_RST = BW'(FLT_INI);

  logic           en_reg;
  logic [15:0]    presc_reg;
  logic [15:0]    cnt_reg;
  logic           refclk_reg;
  logic [NCH-1:0] pol_reg;
  logic [NCH-1:0] act_en_reg;
  logic [NCH-1:0] inact_en_reg;
  logic [NCH-1:0] act_st_reg;
  logic [NCH-1:0] inact_st_reg;
  logic           irq_reg;
  logic [31:0]    rdata_reg;
  logic           rvalid_reg;
  logic [31:0]    rd_word;

  logic           ctrl_wr;
  logic           st_wr;
  logic [NCH-1:0] act_clr;
  logic [NCH-1:0] inact_clr;

  // Only a subset of wdata bits is architected for small NCH/BW.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  assign ctrl_wr   = we && (addr == 4'h0);
  assign st_wr     = we && (addr == 4'h3);
  assign act_clr   = st_wr ? wdata[NCH-1:0]  : '0;
  assign inact_clr = st_wr ? wdata[8 +: NCH] : '0;

  // Control, polarity and interrupt-enable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg       <= 1'b0;
      presc_reg    <= PRESC_INI;
      pol_reg      <= '0;
      act_en_reg   <= '0;
      inact_en_reg <= '0;
    end else if (we) begin
      case (addr)
        4'h0: begin
          en_reg    <= wdata[0];
          presc_reg <= wdata[31:16];
        end
        4'h1: pol_reg <= wdata[NCH-1:0];
        4'h2: begin
          act_en_reg   <= wdata[NCH-1:0];
          inact_en_reg <= wdata[8 +: NCH];
        end
        default: ;
      endcase
    end
  end

  // Per-channel filter time registers, driven straight onto the outputs
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [BW-1:0] rise_reg;
    logic [BW-1:0] fall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rise_reg <= FLT_RST;
        fall_reg <= FLT_RST;
      end else if (we && (addr == 4'(8 + gi))) begin
        rise_reg <= wdata[BW-1:0];
        fall_reg <= wdata[16 +: BW];
      end
    end

    assign flt_rise_st[gi*BW +: BW] = rise_reg;
    assign flt_fall_st[gi*BW +: BW] = fall_reg;
  end

  // Prescaler: the compare against presc (rather than an overflow check)
  // keeps presc=16'hFFFF a plain 65536-clock period. A CTRL write restarts
  // the phase and masks the strobe for one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= 16'd0;
      refclk_reg <= 1'b0;
    end else if (ctrl_wr || !en_reg) begin
      cnt_reg    <= 16'd0;
      refclk_reg <= 1'b0;
    end else begin
      refclk_reg <= (cnt_reg == presc_reg);
      cnt_reg    <= (cnt_reg == presc_reg) ? 16'd0 : cnt_reg + 16'd1;
    end
  end

  // Sticky status: the OR of new edges comes after the clear so a
  // simultaneous edge wins over a W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_st_reg   <= '0;
      inact_st_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      act_st_reg   <= (act_st_reg & ~act_clr) | act_edge;
      inact_st_reg <= (inact_st_reg & ~inact_clr) | inact_edge;
      irq_reg      <= |((act_st_reg & act_en_reg) | (inact_st_reg & inact_en_reg));
    end
  end

  // Read mux works on current register contents, so a same-cycle write
  // is not visible to the read.
  always_comb begin
    rd_word = '0;
    case (addr)
      4'h0: begin
        rd_word[0]     = en_reg;
        rd_word[31:16] = presc_reg;
      end
      4'h1: rd_word[NCH-1:0] = pol_reg;
      4'h2: begin
        rd_word[NCH-1:0]  = act_en_reg;
        rd_word[8 +: NCH] = inact_en_reg;
      end
      4'h3: begin
        rd_word[NCH-1:0]  = act_st_reg;
        rd_word[8 +: NCH] = inact_st_reg;
      end
      4'h4: rd_word[NCH-1:0] = flt_level;
      default: begin
        for (int n = 0; n < NCH; n++) begin
          if (addr == 4'(8 + n)) begin
            rd_word[BW-1:0]  = flt_rise_st[n*BW +: BW];
            rd_word[16 +: BW] = flt_fall_st[n*BW +: BW];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg  <= 32'd0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= re;
      if (re) begin
        rdata_reg <= rd_word;
      end
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;
  assign refclk = refclk_reg;
  assign pol    = pol_reg;
  assign irq    = irq_reg;

endmodule

// File: tb/tb_dfilter_ctrl.sv
module tb_dfilter_ctrl;
  localparam int NCH = 4;
  localparam int BW  = 8;
  localparam logic [7:0] MASK = 8'h0F;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              we = 1'b0;
  logic              re = 1'b0;
  logic [3:0]        addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              refclk;
  logic [NCH-1:0]    pol;
  logic [NCH*BW-1:0] flt_rise_st;
  logic [NCH*BW-1:0] flt_fall_st;
  logic [NCH-1:0]    flt_level = '0;
  logic [NCH-1:0]    act_edge = '0;
  logic [NCH-1:0]    inact_edge = '0;
  logic              irq;

  dfilter_ctrl #(.NCH(NCH), .BW(BW), .PRESC_INI(16'd0), .FLT_INI(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .refclk(refclk), .pol(pol),
    .flt_rise_st(flt_rise_st), .flt_fall_st(flt_fall_st),
    .flt_level(flt_level), .act_edge(act_edge), .inact_edge(inact_edge),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          edge_n = 0;
  int          m_wedge = 0;   // edge index of last prescaler restart
  logic        m_en;
  logic [15:0] m_presc;
  logic        m_refclk, m_irq, m_rvalid;
  logic [31:0] m_rdata;
  logic [7:0]  m_pol, m_aen, m_ien, m_ast, m_ist;
  int          m_rise [NCH];
  int          m_fall [NCH];

  function automatic logic [31:0] m_read(logic [3:0] a);
    int i;
    i = int'(a) - 8;
    if (a == 4'h0) return {m_presc, 15'd0, m_en};
    if (a == 4'h1) return {24'd0, m_pol};
    if (a == 4'h2) return {16'd0, m_ien, m_aen};
    if (a == 4'h3) return {16'd0, m_ist, m_ast};
    if (a == 4'h4) return {28'd0, flt_level};
    if (i >= 0 && i < NCH) return (32'(m_fall[i]) << 16) | 32'(m_rise[i]);
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_wedge  = edge_n;
    m_en     = 1'b0;
    m_presc  = 16'd0;
    m_refclk = 1'b0;
    m_irq    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = 32'd0;
    m_pol = 8'd0; m_aen = 8'd0; m_ien = 8'd0; m_ast = 8'd0; m_ist = 8'd0;
    for (int n = 0; n < NCH; n++) begin
      m_rise[n] = 255;
      m_fall[n] = 255;
    end
  endtask

  task automatic model_edge();
    logic irq_n;
    int   d;
    int   i;
    edge_n++;
    irq_n = |((m_ast & m_aen) | (m_ist & m_ien));
    m_rvalid = re;
    if (re) m_rdata = m_read(addr);
    if (we) begin
      i = int'(addr) - 8;
      if (addr == 4'h0) begin
        m_en = wdata[0];
        m_presc = wdata[31:16];
        m_wedge = edge_n;
      end else if (addr == 4'h1) m_pol = wdata[7:0] & MASK;
      else if (addr == 4'h2) begin
        m_aen = wdata[7:0] & MASK;
        m_ien = wdata[15:8] & MASK;
      end else if (addr == 4'h3) begin
        m_ast = m_ast & ~wdata[7:0];
        m_ist = m_ist & ~wdata[15:8];
      end else if (i >= 0 && i < NCH) begin
        m_rise[i] = int'(wdata[BW-1:0]);
        m_fall[i] = int'(wdata[16 +: BW]);
      end
    end
    m_ast = m_ast | {4'd0, act_edge};
    m_ist = m_ist | {4'd0, inact_edge};
    m_irq = irq_n;
    // strobe every (presc+1) edges after the restart edge, never on it
    d = edge_n - m_wedge;
    m_refclk = m_en && (d > 0) && ((d % (int'(m_presc) + 1)) == 0);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("refclk", {31'd0, refclk}, {31'd0, m_refclk});
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("rvalid", {31'd0, rvalid}, {31'd0, m_rvalid});
    chk("rdata", rdata, m_rdata);
    chk("pol", {28'd0, pol}, {24'd0, m_pol});
    for (int n = 0; n < NCH; n++) begin
      chk("flt_rise", {24'd0, flt_rise_st[n*BW +: BW]}, 32'(m_rise[n]));
      chk("flt_fall", {24'd0, flt_fall_st[n*BW +: BW]}, 32'(m_fall[n]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    we = 1'b0; re = 1'b0; act_edge = '0; inact_edge = '0;
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
  endtask

  task automatic rd(logic [3:0] a, output logic [31:0] d);
    re = 1'b1; addr = a;
    tick();
    chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
    d = rdata;
  endtask

  logic [31:0] v;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // reset readback
    rd(4'h0, v); chk("rst_ctrl", v, 32'h0000_0000);
    rd(4'h1, v); chk("rst_pol", v, 32'h0000_0000);
    rd(4'h8, v); chk("rst_flt0", v, 32'h00FF_00FF);

    // prescaler period 4, then continuous, then off
    wr(4'h0, 32'h0003_0001);
    chk("p3_k0", {31'd0, refclk}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("p3_refclk", {31'd0, refclk}, (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    wr(4'h0, 32'h0000_0001);
    chk("p0_k0", {31'd0, refclk}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("p0_refclk", {31'd0, refclk}, 32'd1);
    end
    wr(4'h0, 32'h0000_0000);
    tick();
    chk("en0_refclk", {31'd0, refclk}, 32'd0);

    // configuration outputs
    wr(4'hA, 32'h0010_0005);
    chk("flt2_rise", flt_rise_st, 32'hFF05_FFFF);
    chk("flt2_fall", flt_fall_st, 32'hFF10_FFFF);
    wr(4'h1, 32'h0000_0004);
    chk("pol4", {28'd0, pol}, 32'h4);

    // event capture and interrupt
    wr(4'h2, 32'h0000_0001);
    act_edge = 4'b0001; tick();
    chk("irq_lag", {31'd0, irq}, 32'd0);
    rd(4'h3, v); chk("st_act0", v, 32'h0000_0001);
    chk("irq_set", {31'd0, irq}, 32'd1);
    inact_edge = 4'b0010; tick();
    rd(4'h3, v); chk("st_both", v, 32'h0000_0201);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    wr(4'h3, 32'h0000_0001);
    chk("irq_clr_lag", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd(4'h3, v); chk("st_after_clr", v, 32'h0000_0200);

    // set wins over W1C
    act_edge = 4'b0001; tick(); tick();
    act_edge = 4'b0001; we = 1'b1; addr = 4'h3; wdata = 32'h1; tick();
    tick();
    chk("irq_setwins", {31'd0, irq}, 32'd1);
    rd(4'h3, v); chk("st_setwins", v, 32'h0000_0201);

    // read-before-write in the same cycle
    wr(4'h1, 32'h3);
    we = 1'b1; re = 1'b1; addr = 4'h1; wdata = 32'hC; tick();
    chk("rw_old", rdata, 32'h3);
    rd(4'h1, v); chk("rw_new", v, 32'hC);

    // asynchronous reset mid-operation with refclk, irq and rvalid high
    wr(4'h0, 32'h0000_0001);
    tick();
    re = 1'b1; addr = 4'h0;
    @(posedge clk);
    model_edge();
    #1;
    chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
    chk("pre_rst_refclk", {31'd0, refclk}, 32'd1);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_refclk", {31'd0, refclk}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    @(negedge clk);
    re = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      we    = ($urandom % 4) == 0;
      re    = ($urandom % 3) == 0;
      addr  = 4'($urandom);
      wdata = $urandom;
      if (addr == 4'h0) wdata[31:16] = 16'($urandom_range(0, 6));
      if (addr == 4'h0 && ($urandom % 4) != 0) wdata[0] = 1'b1;
      act_edge   = 4'($urandom & $urandom & $urandom);
      inact_edge = 4'($urandom & $urandom & $urandom);
      flt_level  = 4'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dfilter_ctrl.md
Name: dfilter_ctrl

Overview:
- Control and scheduling block for a bank of NCH digital noise filter channels on the board.
- Generates the shared filter sampling strobe (refclk) from a programmable prescaler.
- Holds each channel's polarity and rise/fall filter-time settings in a small register file.
- Captures each channel's active/inactive edge pulses into sticky status bits and raises a level interrupt to the CPU bus side.

Parameters:
NCH, 4, number of filter channels (1..8)
BW, 8, filter time setting width per channel (1..16)
PRESC_INI, 16'd0, prescaler reload value after reset
FLT_INI, 8'hFF, reset value of every rise/fall setting (truncated/zero-extended to BW)

Ports:
clk  in  1  Global Clock
rst_n  in  1  Global Reset, asynchronous, active-low
we  in  1  register write strobe, 1 clk
re  in  1  register read strobe, 1 clk
addr  in  4  register address
wdata  in  32  write data
rdata  out  32  read data, registered
rvalid  out  1  read data valid, 1 clk pulse
refclk  out  1  filter sampling strobe, 1 clk pulse, shared by all channels
pol  out  NCH  per-channel polarity (0: Low Active / 1: High Active)
flt_rise_st  out  NCH*BW  per-channel rise filter time, channel n at [n*BW +: BW]
flt_fall_st  out  NCH*BW  per-channel fall filter time, same packing
flt_level  in  NCH  per-channel filtered output level
act_edge  in  NCH  per-channel active-edge pulse
inact_edge  in  NCH  per-channel inactive-edge pulse
irq  out  1  interrupt, level, registered

Behaviour:
- Reset values:
  - rdata=0, rvalid=0, refclk=0, pol=0, irq=0
  - flt_rise_st and flt_fall_st = FLT_INI for all channels
  - CTRL.en=0, CTRL.presc=PRESC_INI, IRQ_EN=0, STATUS=0, prescaler count=0
- Register map (unlisted bits read 0, writes to them are ignored):
  - 0x0 CTRL, RW: [0] en, [31:16] presc
  - 0x1 POL, RW: [NCH-1:0]
  - 0x2 IRQ_EN, RW: [7:0] act enable per channel, [15:8] inact enable per channel
  - 0x3 STATUS, R/W1C: [7:0] act sticky, [15:8] inact sticky
  - 0x4 LEVEL, RO: flt_level
  - 0x8+n FLTn (n<NCH), RW: [BW-1:0] rise, [BW+15:16] fall
  - Unmapped addresses, and FLTn with n>=NCH: read 0, writes ignored.
- Bus handshake:
  - A write takes effect on the clk edge where we=1.
  - re=1 at cycle t gives rdata and rvalid=1 at t+1. rdata holds its value until the next read.
  - we and re in the same cycle: both are performed, and the read returns the pre-write value.
- Prescaler:
  - With en=1, cnt counts 0..presc and wraps to 0. refclk=1 (registered) in the cycle after cnt==presc, so the period is presc+1 clks.
  - presc=0 gives refclk high every clk.
  - With en=0, cnt is held at 0 and refclk=0.
  - Any write to CTRL clears cnt to 0 and suppresses refclk in the following cycle, so the new period starts cleanly.
  - presc=16'hFFFF is valid: period 65536, no overflow.
- Event capture:
  - STATUS bit sets on the edge where its act_edge/inact_edge input is 1, regardless of IRQ_EN.
  - A W1C write to a bit clears it.
  - Set and clear in the same cycle: set wins.
  - Writing 0 leaves a bit unchanged.
- Interrupt: irq <= |(STATUS & IRQ_EN), registered, so irq asserts 1 clk after the STATUS bit is set and deasserts 1 clk after the clear.
- Config outputs (pol, flt_*_st) are driven directly from registers and update the cycle after the write.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and any pending rvalid is dropped.

Test Plan:
- Reset, then read 0x0, 0x1, 0x8 -> rdata = 0x00000000, 0x00000000, 0x00FF00FF (BW=8), each with rvalid 1 clk after re.
- Write CTRL=0x0003_0001 -> refclk pulses every 4 clks. Then write presc=0 -> refclk continuous high, starting 2 clks after the write. Then write en=0 -> refclk=0.
- Write FLT2=0x0010_0005, POL=0x4 -> flt_rise_st[23:16]=0x05, flt_fall_st[23:16]=0x10, pol=4'b0100 on the next clk; the other channels are unchanged.
- IRQ_EN=0x0001, pulse act_edge[0] -> STATUS=0x0001 and irq=1 one clk later. Pulse inact_edge[1] -> STATUS=0x0201, irq stays 1. Write STATUS=0x0001 -> irq=0, STATUS=0x0200.
- W1C of STATUS bit0 in the same clk as an act_edge[0] pulse -> bit0 stays 1 and irq stays asserted.
- we+re to POL in the same clk (old 0x3, new 0xC) -> rdata=0x3; the following read returns 0xC. Assert rst_n low mid-prescale -> refclk, irq, and rvalid are all 0 immediately.
